// File: rtl/mmac_operand_sequencer.sv
// rtl/mmac_operand_sequencer.sv - operand sequencer that drives a MAC to compute C = A x B
// Reads A/B row/column pairs from two synchronous memories and presents each C element on a valid/ready channel.

module mmac_operand_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM = 4,
    localparam int ADDR_WIDTH = $clog2(DIM * DIM),
    localparam int IDX_WIDTH = $clog2(DIM)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  a_rd_en,
    output logic                  b_rd_en,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  mac_enable,
    output logic                  mac_clear,
    output logic [DATA_WIDTH-1:0] mac_matrix_1,
    output logic [DATA_WIDTH-1:0] mac_matrix_2,
    input  logic [DATA_WIDTH-1:0] mac_result,
    output logic                  c_valid,
    input  logic                  c_ready,
    output logic [DATA_WIDTH-1:0] c_data,
    output logic [IDX_WIDTH-1:0]  c_row,
    output logic [IDX_WIDTH-1:0]  c_col
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam logic [IDX_WIDTH-1:0]  LAST  = IDX_WIDTH'(DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] DIM_A = ADDR_WIDTH'(DIM);

    logic [1:0]            state;
    logic [IDX_WIDTH-1:0]  i;
    logic [IDX_WIDTH-1:0]  j;
    logic [IDX_WIDTH-1:0]  k;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_k;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                end
                CLEAR: begin
                    state <= STREAM;
                    k     <= '0;
                end
                STREAM: begin
                    if (k == LAST) begin
                        state <= RESULT;
                        k     <= '0;
                    end else begin
                        k <= k + IDX_WIDTH'(1);
                    end
                end
                RESULT: begin
                    // The accumulator is frozen here, so stalling on c_ready keeps c_data stable.
                    if (c_ready) begin
                        if (i == LAST && j == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            i     <= '0;
                            j     <= '0;
                        end else begin
                            state <= CLEAR;
                            if (j == LAST) begin
                                j <= '0;
                                i <= i + IDX_WIDTH'(1);
                            end else begin
                                j <= j + IDX_WIDTH'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads run one index ahead: CLEAR fetches k=0, STREAM at k fetches k+1.
    always_comb begin
        rd_en  = (state == CLEAR) || (state == STREAM && k != LAST);
        rd_k   = (state == STREAM) ? ADDR_WIDTH'(k) + ADDR_WIDTH'(1) : '0;
        a_addr = '0;
        b_addr = '0;
        if (rd_en) begin
            a_addr = ADDR_WIDTH'(i) * DIM_A + rd_k;
            b_addr = rd_k * DIM_A + ADDR_WIDTH'(j);
        end
    end

    assign a_rd_en      = rd_en;
    assign b_rd_en      = rd_en;
    assign busy         = (state != IDLE);
    assign mac_enable   = (state == STREAM);
    assign mac_clear    = (state == CLEAR);
    assign mac_matrix_1 = mac_enable ? a_rd_data : '0;
    assign mac_matrix_2 = mac_enable ? b_rd_data : '0;
    assign c_valid      = (state == RESULT);
    assign c_data       = c_valid ? mac_result : '0;
    assign c_row        = c_valid ? i : '0;
    assign c_col        = c_valid ? j : '0;

endmodule

// File: tb/tb_mmac_operand_sequencer.sv
// tb/tb_mmac_operand_sequencer.sv - directed bench for mmac_operand_sequencer
// Three instances (16-bit DIM=2, 16-bit DIM=4, 8-bit DIM=2) with behavioural memories and MACs.

module tb_mmac_operand_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic c_ready = 1'b1;
    logic start2 = 1'b0, start4 = 1'b0, start8 = 1'b0;
    int   cyc = 0;
    int   total = 0, bad = 0;
    int   start_cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- instance 2: DATA_WIDTH=16, DIM=2
    logic        s2_busy, s2_done, s2_a_rd_en, s2_b_rd_en, s2_en, s2_clr, s2_c_valid;
    logic [1:0]  s2_a_addr, s2_b_addr;
    logic [15:0] s2_ard, s2_brd, s2_m1, s2_m2, s2_result, s2_c_data, acc2 = '0;
    logic [0:0]  s2_c_row, s2_c_col;
    logic [15:0] a2 [4], b2 [4];

    mmac_operand_sequencer #(.DATA_WIDTH(16), .DIM(2)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2), .busy(s2_busy), .done(s2_done),
        .a_rd_en(s2_a_rd_en), .b_rd_en(s2_b_rd_en), .a_addr(s2_a_addr), .b_addr(s2_b_addr),
        .a_rd_data(s2_ard), .b_rd_data(s2_brd), .mac_enable(s2_en), .mac_clear(s2_clr),
        .mac_matrix_1(s2_m1), .mac_matrix_2(s2_m2), .mac_result(s2_result),
        .c_valid(s2_c_valid), .c_ready(c_ready), .c_data(s2_c_data), .c_row(s2_c_row), .c_col(s2_c_col)
    );

    assign s2_result = s2_en ? s2_m1 * s2_m2 + acc2 : acc2;
    always @(posedge clock) begin
        if (s2_a_rd_en) s2_ard <= a2[s2_a_addr];
        if (s2_b_rd_en) s2_brd <= b2[s2_b_addr];
        if (s2_clr) acc2 <= '0;
        else if (s2_en) acc2 <= s2_result;
    end

    // ---------------- instance 4: DATA_WIDTH=16, DIM=4
    logic        s4_busy, s4_done, s4_a_rd_en, s4_b_rd_en, s4_en, s4_clr, s4_c_valid;
    logic [3:0]  s4_a_addr, s4_b_addr;
    logic [15:0] s4_ard, s4_brd, s4_m1, s4_m2, s4_result, s4_c_data, acc4 = '0;
    logic [1:0]  s4_c_row, s4_c_col;
    logic [15:0] a4 [16], b4 [16];

    mmac_operand_sequencer #(.DATA_WIDTH(16), .DIM(4)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .busy(s4_busy), .done(s4_done),
        .a_rd_en(s4_a_rd_en), .b_rd_en(s4_b_rd_en), .a_addr(s4_a_addr), .b_addr(s4_b_addr),
        .a_rd_data(s4_ard), .b_rd_data(s4_brd), .mac_enable(s4_en), .mac_clear(s4_clr),
        .mac_matrix_1(s4_m1), .mac_matrix_2(s4_m2), .mac_result(s4_result),
        .c_valid(s4_c_valid), .c_ready(c_ready), .c_data(s4_c_data), .c_row(s4_c_row), .c_col(s4_c_col)
    );

    assign s4_result = s4_en ? s4_m1 * s4_m2 + acc4 : acc4;
    always @(posedge clock) begin
        if (s4_a_rd_en) s4_ard <= a4[s4_a_addr];
        if (s4_b_rd_en) s4_brd <= b4[s4_b_addr];
        if (s4_clr) acc4 <= '0;
        else if (s4_en) acc4 <= s4_result;
    end

    // ---------------- instance 8: DATA_WIDTH=8, DIM=2
    logic       s8_busy, s8_done, s8_a_rd_en, s8_b_rd_en, s8_en, s8_clr, s8_c_valid;
    logic [1:0] s8_a_addr, s8_b_addr;
    logic [7:0] s8_ard, s8_brd, s8_m1, s8_m2, s8_result, s8_c_data, acc8 = '0;
    logic [0:0] s8_c_row, s8_c_col;
    logic [7:0] a8 [4], b8 [4];

    mmac_operand_sequencer #(.DATA_WIDTH(8), .DIM(2)) u_dut8 (
        .clock(clock), .reset(reset), .start(start8), .busy(s8_busy), .done(s8_done),
        .a_rd_en(s8_a_rd_en), .b_rd_en(s8_b_rd_en), .a_addr(s8_a_addr), .b_addr(s8_b_addr),
        .a_rd_data(s8_ard), .b_rd_data(s8_brd), .mac_enable(s8_en), .mac_clear(s8_clr),
        .mac_matrix_1(s8_m1), .mac_matrix_2(s8_m2), .mac_result(s8_result),
        .c_valid(s8_c_valid), .c_ready(c_ready), .c_data(s8_c_data), .c_row(s8_c_row), .c_col(s8_c_col)
    );

    assign s8_result = s8_en ? s8_m1 * s8_m2 + acc8 : acc8;
    always @(posedge clock) begin
        if (s8_a_rd_en) s8_ard <= a8[s8_a_addr];
        if (s8_b_rd_en) s8_brd <= b8[s8_b_addr];
        if (s8_clr) acc8 <= '0;
        else if (s8_en) acc8 <= s8_result;
    end

    // ---------------- output monitors, sampled on the falling edge
    int qd2[$], qrc2[$], qc2[$], qd4[$], qrc4[$], qc4[$], qd8[$], qrc8[$];
    int nv2 = 0, nd2 = 0, nd4 = 0, nd8 = 0, ncl4 = 0, nen4 = 0;

    always @(negedge clock) begin
        if (s2_c_valid && c_ready) begin
            qd2.push_back(int'(s2_c_data));
            qrc2.push_back(int'(s2_c_row) * 16 + int'(s2_c_col));
            qc2.push_back(cyc);
        end
        if (s4_c_valid && c_ready) begin
            qd4.push_back(int'(s4_c_data));
            qrc4.push_back(int'(s4_c_row) * 16 + int'(s4_c_col));
            qc4.push_back(cyc);
        end
        if (s8_c_valid && c_ready) begin
            qd8.push_back(int'(s8_c_data));
            qrc8.push_back(int'(s8_c_row) * 16 + int'(s8_c_col));
        end
        if (s2_c_valid) nv2++;
        if (s2_done) nd2++;
        if (s4_done) nd4++;
        if (s8_done) nd8++;
        if (s4_clr) ncl4++;
        if (s4_en) nen4++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic clear_mon();
        qd2.delete(); qrc2.delete(); qc2.delete();
        qd4.delete(); qrc4.delete(); qc4.delete();
        qd8.delete(); qrc8.delete();
        nv2 = 0; nd2 = 0; nd4 = 0; nd8 = 0; ncl4 = 0; nen4 = 0;
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 2) start2 = v;
        else if (w == 4) start4 = v;
        else start8 = v;
    endtask

    function automatic logic done_of(input int w);
        if (w == 2) return s2_done;
        if (w == 4) return s4_done;
        return s8_done;
    endfunction

    function automatic logic busy_of(input int w);
        if (w == 2) return s2_busy;
        if (w == 4) return s4_busy;
        return s8_busy;
    endfunction

    // Drives start just after a rising edge so the following edge accepts it.
    task automatic go(input int w);
        @(posedge clock);
        #1;
        clear_mon();
        set_start(w, 1'b1);
        @(posedge clock);
        #1;
        start_cyc = cyc;
        set_start(w, 1'b0);
    endtask

    task automatic wait_done(input int w, input int budget, input bit pulse);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            if (done_of(w)) seen = 1'b1;
            else if (pulse) begin
                #1;
                start2 = s2_busy && n[0];
            end
        end
        if (seen) chk("busy low with done", busy_of(w), 0);
        #1;
        set_start(w, 1'b0);
        chk("done seen in budget", seen, 1);
    endtask

    task automatic check4(input int w, input int ev [4]);
        int n = (w == 2) ? qd2.size() : qd8.size();
        chk("beat count", n, 4);
        for (int b = 0; b < 4 && b < n; b++) begin
            chk("c_data", (w == 2) ? qd2[b] : qd8[b], ev[b]);
            chk("c_row_col", (w == 2) ? qrc2[b] : qrc8[b], (b / 2) * 16 + (b % 2));
        end
    endtask

    int exp1 [4]  = '{19, 22, 43, 50};
    int exp0 [4]  = '{0, 0, 0, 0};
    int exp30 [4] = '{30, 30, 30, 30};

    initial begin
        int n;
        a2 = '{16'd1, 16'd2, 16'd3, 16'd4};
        b2 = '{16'd5, 16'd6, 16'd7, 16'd8};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a4[r * 4 + c] = (r == c) ? 16'd1 : 16'd0;
                b4[r * 4 + c] = 16'(r * 4 + c);
            end
        end
        for (int x = 0; x < 4; x++) begin
            a8[x] = 8'd16;
            b8[x] = 8'd16;
        end

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst busy", s2_busy, 0);
        chk("rst done", s2_done, 0);
        chk("rst c_valid", s2_c_valid, 0);
        chk("rst rd_en", {s2_a_rd_en, s2_b_rd_en}, 0);
        chk("rst mac ctl", {s2_en, s2_clr}, 0);
        chk("rst addr", {s2_a_addr, s2_b_addr}, 0);
        chk("rst c_data", s2_c_data, 0);
        chk("rst c_row_col", {s2_c_row, s2_c_col}, 0);
        chk("rst busy dim4", s4_busy, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // basic 2x2 multiply with hand-traced first element
        go(2);
        @(negedge clock);
        chk("clear busy/clr/en/rd", {s2_busy, s2_clr, s2_en, s2_a_rd_en}, 4'b1101);
        @(negedge clock);
        chk("stream k0 addr", {s2_a_addr, s2_b_addr}, 4'b0110);
        chk("stream k0 operands", {s2_m1, s2_m2}, {16'd1, 16'd5});
        @(negedge clock);
        chk("stream k1 rd_en", {s2_a_rd_en, s2_b_rd_en}, 0);
        chk("stream k1 operands", {s2_m1, s2_m2}, {16'd2, 16'd7});
        wait_done(2, 40, 1'b0);
        @(negedge clock);
        chk("done one cycle", s2_done, 0);
        chk("done pulses", nd2, 1);
        chk("idle c_data gated", s2_c_data, 0);
        chk("idle operands gated", {s2_m1, s2_m2}, 0);
        check4(2, exp1);
        if (qc2.size() == 4) begin
            chk("first beat cycle", qc2[0] - start_cyc + 1, 4);
            for (int b = 1; b < 4; b++) chk("beat spacing", qc2[b] - qc2[b - 1], 4);
            chk("start to last beat", qc2[3] - start_cyc + 1, 16);
        end

        // back-pressure on element (0,1)
        go(2);
        n = 0;
        while (!(s2_en && !s2_a_rd_en && qd2.size() == 1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("found stream before (0,1)", s2_en && !s2_a_rd_en && qd2.size() == 1, 1);
        @(posedge clock);
        #1 c_ready = 1'b0;
        for (int m = 0; m < 3; m++) begin
            @(negedge clock);
            chk("stall c_valid", s2_c_valid, 1);
            chk("stall c_data", s2_c_data, 22);
            chk("stall rd_en", {s2_a_rd_en, s2_b_rd_en}, 0);
        end
        @(posedge clock);
        #1 c_ready = 1'b1;
        wait_done(2, 40, 1'b0);
        check4(2, exp1);
        if (qc2.size() == 4) chk("stall spacing", qc2[1] - qc2[0], 7);

        // DIM=4 identity times B
        go(4);
        wait_done(4, 150, 1'b0);
        chk("dim4 beats", qd4.size(), 16);
        for (int b = 0; b < 16 && b < qd4.size(); b++) begin
            chk("dim4 c_data", qd4[b], b);
            chk("dim4 c_row_col", qrc4[b], (b / 4) * 16 + (b % 4));
        end
        chk("dim4 mac_clear cycles", ncl4, 16);
        chk("dim4 mac_enable cycles", nen4, 64);
        if (qc4.size() >= 2) chk("dim4 beat spacing", qc4[1] - qc4[0], 6);

        // 8-bit wrap, then small values
        go(8);
        wait_done(8, 40, 1'b0);
        check4(8, exp0);
        for (int x = 0; x < 4; x++) begin
            a8[x] = 8'd3;
            b8[x] = 8'd5;
        end
        go(8);
        wait_done(8, 40, 1'b0);
        check4(8, exp30);

        // reset during STREAM of element (1,0)
        go(2);
        n = 0;
        while (!(s2_en && qd2.size() == 2) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("found stream of (1,0)", s2_en && qd2.size() == 2, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        clear_mon();
        @(negedge clock);
        chk("post-reset busy", s2_busy, 0);
        chk("post-reset rd_en", {s2_a_rd_en, s2_b_rd_en}, 0);
        repeat (3) @(negedge clock);
        chk("no c_valid after reset", nv2, 0);
        go(2);
        wait_done(2, 40, 1'b0);
        check4(2, exp1);

        // start pulsed while busy, then restart right after done
        go(2);
        wait_done(2, 40, 1'b1);
        @(negedge clock);
        chk("pulsed run done pulses", nd2, 1);
        check4(2, exp1);
        #1;
        clear_mon();
        start2 = 1'b1;
        @(posedge clock);
        #1 start2 = 1'b0;
        @(negedge clock);
        chk("restart busy", s2_busy, 1);
        chk("restart mac_clear", s2_clr, 1);
        wait_done(2, 40, 1'b0);
        @(negedge clock);
        chk("restart done pulses", nd2, 1);
        check4(2, exp1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
